i2c_master_byte_seq: RTL and testbench
======================================

// Module: i2c_master_byte_seq
// PURPOSE
//  Byte-level sequencer directly upstream of the I2C bit controller. Turns one byte-level
//  request (START/WRITE/READ/ACK/STOP flags) into a series of single-bit commands.
//  Handshakes each command with the bit controller via core_cmd/core_ack.
//  Shifts 8 data bits MSB-first, then runs the ACK bit. Returns received byte, ACK status
//  and arbitration loss to the APB register block.
// PARAMETERS
//  none (bit-command encodings are fixed: NOP=4'b0000 START=4'b0001 STOP=4'b0010 WRITE=4'b0100 READ=4'b1000)
// PORTS
//  clk       in   1  system clock
//  nReset    in   1  asynchronous, active-low reset
//  ena       in   1  core enable; 0 blocks new requests in IDLE
//  start     in   1  generate (repeated) START before the data phase
//  stop      in   1  generate STOP after the data/ACK phase
//  read      in   1  read one byte from slave
//  write     in   1  write din to slave
//  ack_in    in   1  ACK bit master drives after a read (0=ACK, 1=NACK)
//  din       in   8  byte to transmit
//  cmd_ack   out  1  one-cycle pulse: request complete
//  ack_out   out  1  ACK bit sampled after a write (0=ACK, 1=NACK)
//  dout      out  8  received byte (shift register contents)
//  i2c_al    out  1  one-cycle pulse: arbitration lost
//  core_cmd  out  4  bit command to bit controller
//  core_txd  out  1  bit to transmit (bit controller din)
//  core_ack  in   1  bit controller command-done pulse
//  core_rxd  in   1  bit received (bit controller dout)
//  core_al   in   1  bit controller arbitration-lost flag
// BEHAVIOUR
//  Reset values: state=IDLE, core_cmd=NOP, core_txd=0, cmd_ack=0, ack_out=0, sr(dout)=0, bit_cnt=0, i2c_al=0.
//  go = (start|stop|read|write) & ~cmd_ack & ena; evaluated only in IDLE.
//  States: IDLE, START, WRITE, READ, ACK, STOP.
//  IDLE, go=1: sr<=din, bit_cnt<=7. Next state/core_cmd by priority:
//    start -> START/START; read -> READ/READ; write -> WRITE/WRITE; stop -> STOP/STOP.
//  All non-IDLE states hold core_cmd until core_ack=1.
//  The same cycle core_ack=1, register the next core_cmd. No NOP gap is required.
//  START, core_ack: read -> READ/READ; write -> WRITE/WRITE; else stop -> STOP/STOP.
//    If none of read/write/stop is set: cmd_ack=1, core_cmd=NOP, go to IDLE.
//  WRITE: core_txd=sr[7] while in state.
//    On core_ack: sr<={sr[6:0],1'b0}, bit_cnt--.
//    At bit_cnt==0: go to ACK, core_cmd=READ.
//  READ: on core_ack: sr<={sr[6:0],core_rxd}, bit_cnt--.
//    At bit_cnt==0: go to ACK, core_cmd=WRITE, core_txd=ack_in.
//  read and write both set: read wins.
//  ACK, core_ack: ack_out<=core_rxd.
//    stop=1 -> STOP/STOP; else cmd_ack=1, NOP, IDLE.
//  STOP, core_ack: cmd_ack=1, core_cmd=NOP, go to IDLE.
//  cmd_ack is registered and high for exactly 1 cycle. ~cmd_ack in go blocks same-cycle re-trigger.
//  Latency: cmd_ack follows the final core_ack by 1 clk.
//    Write/read byte with no start/stop = 9 bit commands.
//  core_al=1 in any state: next cycle state=IDLE, core_cmd=NOP, core_txd=0, cmd_ack=0; i2c_al<=core_al.
//    sr/ack_out keep partial values. core_al takes precedence over a coincident core_ack.
//  Inputs start/stop/read/write/din/ack_in must remain stable until cmd_ack; sampled live except din (latched in IDLE).
//  ena=0 mid-transfer does not abort; only new requests are blocked.
// CONFIGURATION
//  I2C_NACK_AUTO_STOP_EN defined: in ACK after a WRITE, core_rxd=1 (NACK) with stop=0 still goes to STOP/STOP.
//    cmd_ack is raised after the STOP completes; ack_out=1.
//  Not defined: a NACK with stop=0 ends at ACK (cmd_ack, IDLE); bus is left held by the master.
// TESTING
//  Model the bit controller as acking each cmd 3 clk after issue; check core_cmd/core_txd sequence.
//  1. start+write, din=8'hA5 -> cmds START, WRITE x8 with txd 1,0,1,0,0,1,0,1, READ;
//     core_rxd=0 on ACK -> ack_out=0, 1-clk cmd_ack, back to IDLE.
//  2. read+ack_in=1+stop, slave bits 8'h3C -> READ x8, WRITE txd=1, STOP; dout=8'h3C, single cmd_ack after STOP ack.
//  3. stop only -> single STOP cmd; cmd_ack 1 clk after its core_ack; no data cmds.
//  4. core_al asserted during 4th WRITE bit -> next clk core_cmd=NOP, i2c_al=1 for 1 clk, no cmd_ack.
//     A new write then starts cleanly.
//  5. write 8'hFF, core_rxd=1 on ACK, stop=0 -> with I2C_NACK_AUTO_STOP_EN: STOP issued then cmd_ack;
//     without: cmd_ack, no STOP.
//  6. Assert nReset mid-READ -> all outputs at reset values asynchronously; ena=0 with write=1 -> core_cmd stays NOP.

Source files
------------

// File: rtl/i2c_master_byte_seq_if.sv
// +----------------------------------------------------------------------------+
// | Module  : i2c_master_byte_seq_if                                           |
// | Desc    : Request/response and bit-controller signals of the byte sequencer|
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface i2c_master_byte_seq_if;
  logic       ena;
  logic       start;
  logic       stop;
  logic       read;
  logic       write;
  logic       ack_in;
  logic [7:0] din;
  logic       cmd_ack;
  logic       ack_out;
  logic [7:0] dout;
  logic       i2c_al;
  logic [3:0] core_cmd;
  logic       core_txd;
  logic       core_ack;
  logic       core_rxd;
  logic       core_al;

  modport master (
    input  ena, start, stop, read, write, ack_in, din,
    input  core_ack, core_rxd, core_al,
    output cmd_ack, ack_out, dout, i2c_al, core_cmd, core_txd
  );

  modport slave (
    output ena, start, stop, read, write, ack_in, din,
    output core_ack, core_rxd, core_al,
    input  cmd_ack, ack_out, dout, i2c_al, core_cmd, core_txd
  );
endinterface

`default_nettype wire

// File: rtl/i2c_master_byte_seq.sv
// +----------------------------------------------------------------------------+
// | Module  : i2c_master_byte_seq                                              |
// | Desc    : Byte-level I2C sequencer issuing single-bit commands; optional   |
// |           feature macro I2C_NACK_AUTO_STOP_EN (STOP after NACK on write).  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module i2c_master_byte_seq (
  input  wire logic              clk,
  input  wire logic              nReset,
  i2c_master_byte_seq_if.master  bus
);

  localparam logic [3:0] c_CMD_NOP   = 4'b0000;
  localparam logic [3:0] c_CMD_START = 4'b0001;
  localparam logic [3:0] c_CMD_STOP  = 4'b0010;
  localparam logic [3:0] c_CMD_WRITE = 4'b0100;
  localparam logic [3:0] c_CMD_READ  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_ACK   = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t     r_state;
  logic [3:0] r_core_cmd;
  logic       r_core_txd;
  logic       r_cmd_ack;
  logic       r_ack_out;
  logic       r_i2c_al;
  logic [7:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic       w_go;
  logic       w_auto_stop;

  assign w_go = (bus.start | bus.stop | bus.read | bus.write) & ~r_cmd_ack & bus.ena;

  // A byte reaching ACK without read set was a write, so core_rxd is the slave's ACK bit.
`ifdef I2C_NACK_AUTO_STOP_EN
  assign w_auto_stop = ~bus.read & bus.core_rxd;
`else
  assign w_auto_stop = 1'b0;
`endif

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state    <= S_IDLE;
      r_core_cmd <= c_CMD_NOP;
      r_core_txd <= 1'b0;
      r_cmd_ack  <= 1'b0;
      r_ack_out  <= 1'b0;
      r_i2c_al   <= 1'b0;
      r_sr       <= 8'h00;
      r_bit_cnt  <= 3'd0;
    end else begin
      r_cmd_ack <= 1'b0;
      r_i2c_al  <= bus.core_al;
      if (bus.core_al) begin
        r_state    <= S_IDLE;
        r_core_cmd <= c_CMD_NOP;
        r_core_txd <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_go) begin
              r_sr      <= bus.din;
              r_bit_cnt <= 3'd7;
              if (bus.start) begin
                r_state <= S_START; r_core_cmd <= c_CMD_START;
              end else if (bus.read) begin
                r_state <= S_READ;  r_core_cmd <= c_CMD_READ;
              end else if (bus.write) begin
                r_state <= S_WRITE; r_core_cmd <= c_CMD_WRITE; r_core_txd <= bus.din[7];
              end else begin
                r_state <= S_STOP;  r_core_cmd <= c_CMD_STOP;
              end
            end
          end
          S_START: begin
            if (bus.core_ack) begin
              if (bus.read) begin
                r_state <= S_READ;  r_core_cmd <= c_CMD_READ;
              end else if (bus.write) begin
                r_state <= S_WRITE; r_core_cmd <= c_CMD_WRITE; r_core_txd <= r_sr[7];
              end else if (bus.stop) begin
                r_state <= S_STOP;  r_core_cmd <= c_CMD_STOP;
              end else begin
                r_state <= S_IDLE;  r_core_cmd <= c_CMD_NOP; r_cmd_ack <= 1'b1;
              end
            end
          end
          S_WRITE: begin
            // core_txd is loaded with the bit that becomes sr[7] after this shift
            if (bus.core_ack) begin
              r_sr      <= {r_sr[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 3'd1;
              if (r_bit_cnt == 3'd0) begin
                r_state <= S_ACK; r_core_cmd <= c_CMD_READ;
              end else begin
                r_core_txd <= r_sr[6];
              end
            end
          end
          S_READ: begin
            if (bus.core_ack) begin
              r_sr      <= {r_sr[6:0], bus.core_rxd};
              r_bit_cnt <= r_bit_cnt - 3'd1;
              if (r_bit_cnt == 3'd0) begin
                r_state <= S_ACK; r_core_cmd <= c_CMD_WRITE; r_core_txd <= bus.ack_in;
              end
            end
          end
          S_ACK: begin
            if (bus.core_ack) begin
              r_ack_out <= bus.core_rxd;
              if (bus.stop | w_auto_stop) begin
                r_state <= S_STOP; r_core_cmd <= c_CMD_STOP;
              end else begin
                r_state <= S_IDLE; r_core_cmd <= c_CMD_NOP; r_cmd_ack <= 1'b1;
              end
            end
          end
          S_STOP: begin
            if (bus.core_ack) begin
              r_state <= S_IDLE; r_core_cmd <= c_CMD_NOP; r_cmd_ack <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE; r_core_cmd <= c_CMD_NOP;
          end
        endcase
      end
    end
  end

  assign bus.core_cmd = r_core_cmd;
  assign bus.core_txd = r_core_txd;
  assign bus.cmd_ack  = r_cmd_ack;
  assign bus.ack_out  = r_ack_out;
  assign bus.dout     = r_sr;
  assign bus.i2c_al   = r_i2c_al;

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_byte_seq.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_i2c_master_byte_seq                                           |
// | Desc    : Bench for i2c_master_byte_seq with a 3-clk bit-controller model  |
// | Rev     : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_i2c_master_byte_seq;

  localparam logic [3:0] c_NOP   = 4'b0000;
  localparam logic [3:0] c_START = 4'b0001;
  localparam logic [3:0] c_STOP  = 4'b0010;
  localparam logic [3:0] c_WRITE = 4'b0100;
  localparam logic [3:0] c_READ  = 4'b1000;

  logic clk = 1'b0;
  logic nReset;
  always #5 clk = ~clk;

  i2c_master_byte_seq_if bus ();

  i2c_master_byte_seq dut (
    .clk    (clk),
    .nReset (nReset),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // bit-controller model and output monitor
  logic [4:0] log_q[$];
  logic [4:0] exp_q[$];
  logic       rx_q[$];
  int         bfm_cnt  = 0;
  int         neg_idx  = 0;
  int         n_cmd_ack = 0;
  int         n_al     = 0;
  int         last_cmd_ack_idx = -10;
  int         last_ack_idx     = -10;

  always @(negedge clk) begin
    neg_idx++;
    if (bus.cmd_ack) begin n_cmd_ack++; last_cmd_ack_idx = neg_idx; end
    if (bus.i2c_al) n_al++;
    if (bus.core_ack) begin
      bus.core_ack = 1'b0;
      bfm_cnt = (bus.core_cmd != c_NOP) ? 1 : 0;
    end else if (bus.core_cmd != c_NOP) begin
      bfm_cnt++;
      if (bfm_cnt == 3) begin
        bus.core_ack = 1'b1;
        last_ack_idx = neg_idx;
        log_q.push_back({bus.core_cmd, (bus.core_cmd == c_WRITE) ? bus.core_txd : 1'b0});
        if (bus.core_cmd == c_READ)
          bus.core_rxd = (rx_q.size() > 0) ? rx_q.pop_front() : 1'b0;
        else if (bus.core_cmd == c_WRITE)
          bus.core_rxd = bus.core_txd;
        else
          bus.core_rxd = 1'b0;
      end
    end else begin
      bfm_cnt = 0;
    end
  end

  // reference results of the last transaction
  logic [7:0] exp_dout;
  logic       m_ack_out = 1'b0;
  int         obs_timeout, obs_seq_err, obs_lat, obs_nack, obs_idle_cmd;

  task automatic clear_inputs();
    bus.start = 0; bus.stop = 0; bus.read = 0; bus.write = 0;
  endtask

  task automatic run_txn(input logic st, input logic sp, input logic rd, input logic wr,
                         input logic [7:0] d, input logic ai, input logic [7:0] sb,
                         input logic sa);
    int base, cyc;
    logic auto_stop;
    exp_q.delete(); rx_q.delete(); log_q.delete();
    if (st) exp_q.push_back({c_START, 1'b0});
    if (rd) begin
      for (int i = 7; i >= 0; i--) begin exp_q.push_back({c_READ, 1'b0}); rx_q.push_back(sb[i]); end
      exp_q.push_back({c_WRITE, ai});
      m_ack_out = ai;
    end else if (wr) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back({c_WRITE, d[i]});
      exp_q.push_back({c_READ, 1'b0});
      rx_q.push_back(sa);
      m_ack_out = sa;
    end
    auto_stop = 1'b0;
`ifdef I2C_NACK_AUTO_STOP_EN
    auto_stop = wr & ~rd & sa;
`endif
    if (sp || auto_stop) exp_q.push_back({c_STOP, 1'b0});
    exp_dout = rd ? sb : (wr ? 8'h00 : d);

    base = n_cmd_ack;
    bus.start = st; bus.stop = sp; bus.read = rd; bus.write = wr;
    bus.din = d; bus.ack_in = ai; bus.ena = 1'b1;
    cyc = 0;
    while (n_cmd_ack == base && cyc < 400) begin @(negedge clk); #1; cyc++; end
    obs_timeout = (n_cmd_ack == base) ? 1 : 0;
    clear_inputs();
    obs_lat = last_cmd_ack_idx - last_ack_idx;
    obs_seq_err = -1;
    for (int i = 0; i < exp_q.size() || i < log_q.size(); i++) begin
      if (obs_seq_err == -1 && (i >= exp_q.size() || i >= log_q.size() || exp_q[i] !== log_q[i]))
        obs_seq_err = i;
    end
    repeat (5) begin @(negedge clk); #1; end
    obs_nack = n_cmd_ack - base;
    obs_idle_cmd = int'(bus.core_cmd);
  endtask

  task automatic report_seq(input string name);
    checks++;
    if (obs_seq_err != -1) begin
      failures++;
      $display("FAIL %s_seq idx=%0d got=%0h exp=%0h got_len=%0d exp_len=%0d", name, obs_seq_err,
               (obs_seq_err < log_q.size()) ? log_q[obs_seq_err] : 5'h1f,
               (obs_seq_err < exp_q.size()) ? exp_q[obs_seq_err] : 5'h1f, log_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.core_cmd !== c_NOP || bus.core_txd !== 1'b0 || bus.cmd_ack !== 1'b0 ||
        bus.ack_out !== 1'b0 || bus.dout !== 8'h00 || bus.i2c_al !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got cmd=%0h txd=%0b cack=%0b ack=%0b dout=%0h al=%0b exp all zero",
               bus.core_cmd, bus.core_txd, bus.cmd_ack, bus.ack_out, bus.dout, bus.i2c_al);
    end
  endtask

  task automatic test_start_write();
    run_txn(1, 0, 0, 1, 8'hA5, 0, 8'h00, 0);
    checks++; if (obs_timeout != 0) begin failures++; $display("FAIL sw_timeout got=1 exp=0"); end
    report_seq("sw");
    checks++; if (obs_lat != 1) begin failures++; $display("FAIL sw_latency got=%0d exp=1", obs_lat); end
    checks++; if (obs_nack != 1) begin failures++; $display("FAIL sw_cmd_ack_count got=%0d exp=1", obs_nack); end
    checks++; if (bus.ack_out !== 1'b0) begin failures++; $display("FAIL sw_ack_out got=%0b exp=0", bus.ack_out); end
    checks++; if (obs_idle_cmd != 0) begin failures++; $display("FAIL sw_idle_cmd got=%0h exp=0", obs_idle_cmd); end
  endtask

  task automatic test_read_stop();
    run_txn(0, 1, 1, 0, 8'h00, 1, 8'h3C, 0);
    report_seq("rs");
    checks++; if (bus.dout !== 8'h3C) begin failures++; $display("FAIL rs_dout got=%0h exp=3c", bus.dout); end
    checks++; if (obs_nack != 1) begin failures++; $display("FAIL rs_cmd_ack_count got=%0d exp=1", obs_nack); end
    checks++; if (obs_lat != 1) begin failures++; $display("FAIL rs_latency got=%0d exp=1", obs_lat); end
    checks++; if (bus.ack_out !== 1'b1) begin failures++; $display("FAIL rs_ack_out got=%0b exp=1", bus.ack_out); end
  endtask

  task automatic test_stop_only();
    run_txn(0, 1, 0, 0, 8'h5A, 0, 8'h00, 0);
    report_seq("stop");
    checks++; if (log_q.size() != 1) begin failures++; $display("FAIL stop_cmd_count got=%0d exp=1", log_q.size()); end
    checks++; if (obs_lat != 1) begin failures++; $display("FAIL stop_latency got=%0d exp=1", obs_lat); end
  endtask

  task automatic test_arb_lost();
    int base, cyc;
    log_q.delete(); rx_q.delete();
    bus.din = 8'h96; bus.start = 1; bus.write = 1; bus.ena = 1;
    cyc = 0;
    while (log_q.size() < 4 && cyc < 200) begin @(negedge clk); #1; cyc++; end
    checks++; if (log_q.size() < 4) begin failures++; $display("FAIL al_reach_bit4 got=%0d exp=4", log_q.size()); end
    @(negedge clk); #1;
    base = n_cmd_ack;
    bus.core_al = 1'b1;
    @(negedge clk); #1;
    checks++; if (bus.core_cmd !== c_NOP) begin failures++; $display("FAIL al_cmd got=%0h exp=0", bus.core_cmd); end
    checks++; if (bus.i2c_al !== 1'b1) begin failures++; $display("FAIL al_flag got=%0b exp=1", bus.i2c_al); end
    bus.core_al = 1'b0;
    clear_inputs();
    @(negedge clk); #1;
    checks++; if (bus.i2c_al !== 1'b0) begin failures++; $display("FAIL al_pulse got=%0b exp=0", bus.i2c_al); end
    repeat (10) begin @(negedge clk); #1; end
    checks++; if (n_cmd_ack != base) begin failures++; $display("FAIL al_no_cmd_ack got=%0d exp=0", n_cmd_ack - base); end
    run_txn(0, 0, 0, 1, 8'h4E, 0, 8'h00, 0);
    report_seq("al_recover");
    checks++; if (obs_nack != 1) begin failures++; $display("FAIL al_recover_cmd_ack got=%0d exp=1", obs_nack); end
  endtask

  task automatic test_nack();
    run_txn(0, 0, 0, 1, 8'hFF, 0, 8'h00, 1);
    report_seq("nack");
    checks++; if (bus.ack_out !== 1'b1) begin failures++; $display("FAIL nack_ack_out got=%0b exp=1", bus.ack_out); end
    checks++; if (obs_nack != 1) begin failures++; $display("FAIL nack_cmd_ack got=%0d exp=1", obs_nack); end
  endtask

  task automatic test_async_reset_ena();
    int cyc, bad, base;
    log_q.delete(); rx_q.delete();
    bus.read = 1; bus.ena = 1;
    cyc = 0;
    while (log_q.size() < 3 && cyc < 200) begin @(negedge clk); #1; cyc++; end
    #2 nReset = 1'b0;
    #1;
    m_ack_out = 1'b0;
    checks++;
    if (bus.core_cmd !== c_NOP || bus.core_txd !== 1'b0 || bus.cmd_ack !== 1'b0 ||
        bus.ack_out !== 1'b0 || bus.dout !== 8'h00 || bus.i2c_al !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got cmd=%0h dout=%0h ack=%0b exp all zero", bus.core_cmd, bus.dout, bus.ack_out);
    end
    clear_inputs();
    repeat (3) @(negedge clk);
    #1 nReset = 1'b1;
    base = n_cmd_ack;
    bus.ena = 0; bus.write = 1; bus.din = 8'hC3;
    bad = 0;
    repeat (10) begin @(negedge clk); #1; if (bus.core_cmd !== c_NOP) bad++; end
    checks++; if (bad != 0) begin failures++; $display("FAIL ena_block got=%0d active cycles exp=0", bad); end
    checks++; if (n_cmd_ack != base) begin failures++; $display("FAIL ena_no_cmd_ack got=%0d exp=0", n_cmd_ack - base); end
    bus.write = 0; bus.ena = 1;
  endtask

  task automatic test_random();
    logic [3:0] f;
    logic [7:0] d, sb;
    logic ai, sa;
    for (int n = 0; n < 24; n++) begin
      f  = 4'($urandom_range(1, 15));
      d  = 8'($urandom); sb = 8'($urandom);
      ai = 1'($urandom); sa = 1'($urandom);
      run_txn(f[0], f[1], f[2], f[3], d, ai, sb, sa);
      checks++; if (obs_timeout != 0) begin failures++; $display("FAIL rnd%0d_timeout flags=%0h", n, f); end
      report_seq($sformatf("rnd%0d", n));
      checks++; if (obs_nack != 1 || obs_lat != 1) begin
        failures++; $display("FAIL rnd%0d_cmd_ack got count=%0d lat=%0d exp 1/1", n, obs_nack, obs_lat); end
      checks++; if (bus.dout !== exp_dout) begin
        failures++; $display("FAIL rnd%0d_dout got=%0h exp=%0h", n, bus.dout, exp_dout); end
      checks++; if (bus.ack_out !== m_ack_out) begin
        failures++; $display("FAIL rnd%0d_ack_out got=%0b exp=%0b", n, bus.ack_out, m_ack_out); end
    end
  endtask

  initial begin
    nReset = 1'b0;
    bus.ena = 1'b1; bus.ack_in = 1'b0; bus.din = 8'h00;
    bus.core_ack = 1'b0; bus.core_rxd = 1'b0; bus.core_al = 1'b0;
    clear_inputs();
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    nReset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    test_start_write();
    test_read_stop();
    test_stop_only();
    test_arb_lost();
    test_nack();
    test_async_reset_ena();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
